// File: rtl/qsfp_port_pkg.sv
// Shared types and sizing helpers for the QSFP cage supervisor.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package qsfp_port_pkg;

    typedef enum logic [2:0] {
        ABSENT = 3'd0,
        RESET  = 3'd1,
        INIT   = 3'd2,
        READY  = 3'd3,
        ACTIVE = 3'd4
    } port_state_t;

    localparam int MIN_CNT_W = 1;

    // Cycles per microsecond; clamped so a sub-MHz clock still ticks every cycle.
    function automatic int us_cycles(input int clock_frequency);
        int c;
        c = clock_frequency / 1_000_000;
        return (c < 1) ? 1 : c;
    endfunction

    // Width of a counter that must hold values 0..max_value.
    function automatic int cnt_width(input int max_value);
        int w;
        w = $clog2(max_value + 1);
        return (w < MIN_CNT_W) ? MIN_CNT_W : w;
    endfunction

    function automatic int timer_width(input int reset_pulse_us, input int init_wait_us);
        return cnt_width((reset_pulse_us > init_wait_us) ? reset_pulse_us : init_wait_us);
    endfunction

endpackage

// File: rtl/qsfp_presence_debounce.sv
// Synchronises one raw ModPrsL and debounces it on microsecond ticks; present = ~debounced level.
// Latency: 2 sync cycles + DEBOUNCE_US ticks + 1 cycle to flip the debounced level.
// Backpressure: none; free-running sampler.
module qsfp_presence_debounce
    import qsfp_port_pkg::*;
#(
    parameter int DEBOUNCE_US = 10000
) (
    input  logic system_clock,
    input  logic system_reset,
    input  logic us_tick,
    input  logic modprsl,
    output logic present
);

    localparam int CNT_W = cnt_width(DEBOUNCE_US);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Sync chain and debounced level idle high (no module) so reset reads as absent.
    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
        end else begin
            sync_a <= modprsl;
            sync_b <= sync_a;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt >= CNT_W'(DEBOUNCE_US)) begin
                level <= sync_b;
                cnt   <= '0;
            end else if (us_tick) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign present = ~level;

endmodule

// File: rtl/qsfp_port_manager.sv
// Per-cage ModPrsL debounce, ResetL pulse + init wait, HPD and {active,ready} LEDs; QSFP_PORT_MANAGER_BLINK_EN blinks the ready LED.
// Latency: outputs registered, change one cycle after the causing event.
// Backpressure: none; channels are independent and always serviced.
module qsfp_port_manager
    import qsfp_port_pkg::*;
#(
    parameter int CHANNELS        = 1,
    parameter int CLOCK_FREQUENCY = 200_000_000,
    parameter int DEBOUNCE_US     = 10000,
    parameter int RESET_PULSE_US  = 10,
    parameter int INIT_WAIT_US    = 2000000,
    parameter int BLINK_HALF_US   = 250000
) (
    input  logic                  system_clock,
    input  logic                  system_reset,
    input  logic [CHANNELS-1:0]   modprsl,
    input  logic [CHANNELS-1:0]   restart,
    input  logic [CHANNELS-1:0]   run,
    output logic [CHANNELS-1:0]   resetl,
    output logic [CHANNELS-1:0]   hpd,
    output logic [2*CHANNELS-1:0] led
);

    localparam int US_CYC = us_cycles(CLOCK_FREQUENCY);
    localparam int PRE_W  = cnt_width(US_CYC);
    localparam int TMR_W  = timer_width(RESET_PULSE_US, INIT_WAIT_US);

    logic [PRE_W-1:0] pre_cnt;
    logic             us_tick;

    assign us_tick = (pre_cnt == PRE_W'(US_CYC - 1));

    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            pre_cnt <= '0;
        end else if (us_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

`ifdef QSFP_PORT_MANAGER_BLINK_EN
    localparam int BLK_W = cnt_width(BLINK_HALF_US);

    logic [BLK_W-1:0] blink_cnt;
    logic             blink_phase;

    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (us_tick) begin
            if (blink_cnt == BLK_W'(BLINK_HALF_US - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`endif

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic             present;
        port_state_t      state_q;
        port_state_t      state_d;
        logic [TMR_W-1:0] timer_q;
        logic             timer_clr;
        logic             resetl_q;
        logic             hpd_q;
        logic [1:0]       led_q;
        logic             ready_led;

        qsfp_presence_debounce #(
            .DEBOUNCE_US (DEBOUNCE_US)
        ) u_debounce (
            .system_clock (system_clock),
            .system_reset (system_reset),
            .us_tick      (us_tick),
            .modprsl      (modprsl[ch]),
            .present      (present)
        );

        // Loss of presence beats restart, which beats the normal progression.
        always_comb begin
            state_d   = state_q;
            timer_clr = 1'b0;
            if (!present) begin
                state_d = ABSENT;
            end else begin
                case (state_q)
                    ABSENT:  state_d = RESET;
                    RESET:   if (timer_q >= TMR_W'(RESET_PULSE_US)) state_d = INIT;
                    INIT:    if (timer_q >= TMR_W'(INIT_WAIT_US))   state_d = READY;
                    READY:   if (run[ch])  state_d = ACTIVE;
                    ACTIVE:  if (!run[ch]) state_d = READY;
                    default: state_d = ABSENT;
                endcase
                if (restart[ch] && (state_q != ABSENT)) begin
                    state_d   = RESET;
                    timer_clr = 1'b1;
                end
            end
            if (state_d != state_q) begin
                timer_clr = 1'b1;
            end
        end

`ifdef QSFP_PORT_MANAGER_BLINK_EN
        assign ready_led = (state_d == RESET) ||
                           (blink_phase && ((state_d == READY) || (state_d == INIT)));
`else
        assign ready_led = (state_d == READY);
`endif

        // Outputs decode the next state so they move in the same cycle as the state register.
        always_ff @(posedge system_clock) begin
            if (system_reset) begin
                state_q  <= ABSENT;
                timer_q  <= '0;
                resetl_q <= 1'b0;
                hpd_q    <= 1'b0;
                led_q    <= 2'b00;
            end else begin
                state_q <= state_d;
                if (timer_clr) begin
                    timer_q <= '0;
                end else if (us_tick && (timer_q != '1)) begin
                    timer_q <= timer_q + 1'b1;
                end
                resetl_q <= (state_d == INIT) || (state_d == READY) || (state_d == ACTIVE);
                hpd_q    <= (state_d == READY) || (state_d == ACTIVE);
                led_q    <= {(state_d == ACTIVE), ready_led};
            end
        end

        assign resetl[ch]       = resetl_q;
        assign hpd[ch]          = hpd_q;
        assign led[2*ch +: 2]   = led_q;
    end

endmodule

// File: tb/tb_qsfp_port_manager.sv
// Directed bench for qsfp_port_manager with two cages at a 1 MHz clock (one us_tick per cycle).
// Latency: checks sequencing windows in cycles from the first sampling edge.
// Backpressure: n/a.
module tb_qsfp_port_manager;

    logic       system_clock = 1'b0;
    logic       system_reset;
    logic [1:0] modprsl;
    logic [1:0] restart;
    logic [1:0] run;
    logic [1:0] resetl;
    logic [1:0] hpd;
    logic [3:0] led;

    int total = 0;
    int bad   = 0;

    always #5 system_clock = ~system_clock;

    qsfp_port_manager #(
        .CHANNELS        (2),
        .CLOCK_FREQUENCY (1_000_000),
        .DEBOUNCE_US     (8),
        .RESET_PULSE_US  (10),
        .INIT_WAIT_US    (20),
        .BLINK_HALF_US   (4)
    ) dut (
        .system_clock (system_clock),
        .system_reset (system_reset),
        .modprsl      (modprsl),
        .restart      (restart),
        .run          (run),
        .resetl       (resetl),
        .hpd          (hpd),
        .led          (led)
    );

    typedef struct {
        logic [1:0] modprsl;
        logic [1:0] restart;
        logic [1:0] run;
        int         wait_n;
        logic [1:0] exp_resetl;
        logic [1:0] exp_hpd;
        logic [3:0] exp_led;
    } vec_t;

    vec_t va[4];
    vec_t vb[4];

    task automatic check_out(input string name, input logic [1:0] e_rl,
                             input logic [1:0] e_hpd, input logic [3:0] e_led);
        total++;
        if ({resetl, hpd, led} !== {e_rl, e_hpd, e_led}) begin
            bad++;
            $display("FAIL %s: got resetl=%b hpd=%b led=%b want resetl=%b hpd=%b led=%b",
                     name, resetl, hpd, led, e_rl, e_hpd, e_led);
        end
    endtask

    task automatic check_range(input string name, input bit found, input int act,
                               input int lo, input int hi);
        total++;
        if (!found || act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: found=%0d got %0d cycles want %0d..%0d", name, found, act, lo, hi);
        end
    endtask

    task automatic apply(input vec_t v);
        modprsl = v.modprsl;
        restart = v.restart;
        run     = v.run;
        repeat (v.wait_n) @(negedge system_clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        bit saw_init;
        int t;

        // Absent-cage vectors: glitch rejection and restart ignored while ABSENT.
        va[0] = '{2'b10, 2'b00, 2'b00,  5, 2'b00, 2'b00, 4'b0000};
        va[1] = '{2'b11, 2'b00, 2'b00, 30, 2'b00, 2'b00, 4'b0000};
        va[2] = '{2'b11, 2'b11, 2'b00,  1, 2'b00, 2'b00, 4'b0000};
        va[3] = '{2'b11, 2'b00, 2'b00, 30, 2'b00, 2'b00, 4'b0000};
        // Channel 0 READY: run toggling, steady ready LED, ends in ACTIVE.
        vb[0] = '{2'b10, 2'b00, 2'b01,  1, 2'b01, 2'b01, 4'b0010};
        vb[1] = '{2'b10, 2'b00, 2'b00,  1, 2'b01, 2'b01, 4'b0001};
        vb[2] = '{2'b10, 2'b00, 2'b00,  8, 2'b01, 2'b01, 4'b0001};
        vb[3] = '{2'b10, 2'b00, 2'b01,  2, 2'b01, 2'b01, 4'b0010};

        system_reset = 1'b1;
        modprsl      = 2'b11;
        restart      = 2'b00;
        run          = 2'b00;
        repeat (3) @(negedge system_clock);
        check_out("reset_state", 2'b00, 2'b00, 4'b0000);
        system_reset = 1'b0;

        for (int i = 0; i < 100; i++) begin
            @(negedge system_clock);
            check_out($sformatf("idle_absent_%0d", i), 2'b00, 2'b00, 4'b0000);
        end

        for (int i = 0; i < 4; i++) begin
            apply(va[i]);
            check_out($sformatf("vec_a_%0d", i), va[i].exp_resetl, va[i].exp_hpd, va[i].exp_led);
        end

        // Insertion on channel 0: first sampling edge counts as cycle 0.
        modprsl = 2'b10;
        found = 1'b0;
        t = 0;
        for (int k = 1; k <= 60 && !found; k++) begin
            @(negedge system_clock);
            if (resetl[0]) begin
                found = 1'b1;
                t = k - 1;
            end
        end
        check_range("resetl0_rise", found, t, 20, 22);
        check_out("resetl0_ch1_idle", 2'b01, 2'b00, 4'b0000);

        found = 1'b0;
        t = 0;
        for (int k = 1; k <= 40 && !found; k++) begin
            @(negedge system_clock);
            if (hpd[0]) begin
                found = 1'b1;
                t = k;
            end
        end
        check_range("hpd0_after_resetl", found, t, 19, 21);
        check_out("ready0", 2'b01, 2'b01, 4'b0001);

        for (int i = 0; i < 4; i++) begin
            apply(vb[i]);
            check_out($sformatf("vec_b_%0d", i), vb[i].exp_resetl, vb[i].exp_hpd, vb[i].exp_led);
        end

        // Restart together with removal: RESET at once, then ABSENT without INIT.
        modprsl = 2'b11;
        restart = 2'b01;
        @(negedge system_clock);
        check_out("restart_to_reset", 2'b00, 2'b00, 4'b0000);
        restart = 2'b00;
        saw_init = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge system_clock);
            if (resetl[0]) saw_init = 1'b1;
        end
        total++;
        if (saw_init) begin
            bad++;
            $display("FAIL never_init: got resetl0 high want always low");
        end
        check_out("absent_after_removal", 2'b00, 2'b00, 4'b0000);

        // Both channels into INIT, then a synchronous reset mid-sequence.
        modprsl = 2'b00;
        run     = 2'b00;
        repeat (30) @(negedge system_clock);
        check_out("both_mid_init", 2'b11, 2'b00, 4'b0000);
        system_reset = 1'b1;
        @(negedge system_clock);
        check_out("sync_reset_clears", 2'b00, 2'b00, 4'b0000);
        system_reset = 1'b0;
        found = 1'b0;
        t = 0;
        for (int k = 1; k <= 60 && !found; k++) begin
            @(negedge system_clock);
            if (resetl != 2'b00) begin
                found = 1'b1;
                t = k - 1;
            end
        end
        check_range("resequence_rise", found, t, 20, 22);
        check_out("resequence_both", 2'b11, 2'b00, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
